// File: rtl/decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Upstream select generator for the decoder3x8 stage. It walks the eight
// select codes {I1,I2,I3} (I1 = MSB) and holds each code with EN=1 for
// DWELL_CYCLES clocks. It can scan continuously, make a single sweep of
// eight codes, or step one code at a time from IDLE.
//
// Build option:
//   GRAY_SEQ_EN - when defined, the code advance follows the 3-bit Gray
//                 sequence 000,001,011,010,110,111,101,100. In that case
//                 START_CODE is taken as a position in the sequence. When
//                 undefined, the code advance is a plain binary +/-1.
//
// Parameters:
//   DWELL_CYCLES - clocks each code is held with EN=1 (1..255)
//   START_CODE   - code loaded at reset and on every START
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   synchronous active-high reset
//   START in   begin a scan from START_CODE (level sampled)
//   STOP  in   abort the scan or step and return to IDLE
//   STEP  in   in IDLE, present the current code for one dwell, then advance
//   MODE  in   0 = continuous scan, 1 = one-shot sweep of 8 codes
//   DIR   in   0 = increment, 1 = decrement
//   EN    out  decoder enable (registered)
//   I1    out  select bit 2 (registered)
//   I2    out  select bit 1 (registered)
//   I3    out  select bit 0 (registered)
//   BUSY  out  high in SCAN or STEP_HOLD
//   DONE  out  one-cycle pulse at the end of a one-shot sweep
// ---------------------------------------------------------------------------
module decoder_scan_sequencer #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter logic [2:0]  START_CODE   = 3'd0
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    input  logic STOP,
    input  logic STEP,
    input  logic MODE,
    input  logic DIR,
    output logic EN,
    output logic I1,
    output logic I2,
    output logic I3,
    output logic BUSY,
    output logic DONE
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SCAN      = 2'd1,
        ST_STEP_HOLD = 2'd2
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
    localparam logic [3:0] SWEEP_MAX  = 4'd8;

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Next select code for one advance in the requested direction.
    function automatic logic [2:0] next_code(input logic [2:0] c, input logic dn);
        logic [2:0] pos;
`ifdef GRAY_SEQ_EN
        // Step the sequence position, then re-encode so only one bit flips.
        pos = gray2bin(c);
        pos = dn ? pos - 3'd1 : pos + 3'd1;
        return bin2gray(pos);
`else
        pos = c;
        return dn ? pos - 3'd1 : pos + 3'd1;
`endif
    endfunction

`ifdef GRAY_SEQ_EN
    localparam logic [2:0] START_SEL = bin2gray(START_CODE);
`else
    localparam logic [2:0] START_SEL = START_CODE;
`endif

    state_t     state_q, state_d;
    logic [2:0] code_q,  code_d;
    logic [7:0] dwell_q, dwell_d;
    logic [3:0] sweep_q, sweep_d;
    logic       en_q,    en_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    logic       dwell_end;

    assign dwell_end = (dwell_q == DWELL_LAST);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        sweep_d = sweep_q;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (START) begin
                    state_d = ST_SCAN;
                    code_d  = START_SEL;
                    dwell_d = '0;
                    sweep_d = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (STEP) begin
                    state_d = ST_STEP_HOLD;
                    dwell_d = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            ST_SCAN: begin
                en_d   = 1'b1;
                busy_d = 1'b1;
                if (STOP) begin
                    state_d = ST_IDLE;
                    dwell_d = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (dwell_end) begin
                    dwell_d = '0;
                    // Saturate so a late switch to one-shot still ends at once.
                    sweep_d = (sweep_q >= SWEEP_MAX) ? SWEEP_MAX : sweep_q + 4'd1;
                    if (MODE && (sweep_q >= SWEEP_MAX - 4'd1)) begin
                        state_d = ST_IDLE;
                        code_d  = START_SEL;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        code_d = next_code(code_q, DIR);
                    end
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end

            ST_STEP_HOLD: begin
                en_d   = 1'b1;
                busy_d = 1'b1;
                if (STOP) begin
                    state_d = ST_IDLE;
                    dwell_d = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (dwell_end) begin
                    state_d = ST_IDLE;
                    dwell_d = '0;
                    code_d  = next_code(code_q, DIR);
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            code_q  <= START_SEL;
            dwell_q <= '0;
            sweep_q <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dwell_q <= dwell_d;
            sweep_q <= sweep_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign EN   = en_q;
    assign I1   = code_q[2];
    assign I2   = code_q[1];
    assign I3   = code_q[0];
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_sequencer
//
// Directed bench. dut uses DWELL_CYCLES=4, START_CODE=0; dut2 uses
// DWELL_CYCLES=1, START_CODE=2. Expected codes are given as sequence
// positions and mapped to binary or Gray codes (GRAY_SEQ_EN).
// ---------------------------------------------------------------------------
module tb_decoder_scan_sequencer;

    logic clk = 1'b0;
    logic rst, start, stop, step, mode, dir;
    logic en, i1, i2, i3, busy, done;
    logic start2, stop2, step2, mode2, dir2;
    logic en2, i1b, i2b, i3b, busy2, done2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL_CYCLES(4), .START_CODE(3'd0)) dut (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop), .STEP(step),
        .MODE(mode), .DIR(dir), .EN(en), .I1(i1), .I2(i2), .I3(i3),
        .BUSY(busy), .DONE(done)
    );

    decoder_scan_sequencer #(.DWELL_CYCLES(1), .START_CODE(3'd2)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .STOP(stop2), .STEP(step2),
        .MODE(mode2), .DIR(dir2), .EN(en2), .I1(i1b), .I2(i2b), .I3(i3b),
        .BUSY(busy2), .DONE(done2)
    );

    // Select code at a given sequence position (taken modulo 8).
    function automatic logic [2:0] seq(input int p);
        int q;
        q = ((p % 8) + 8) % 8;
`ifdef GRAY_SEQ_EN
        case (q)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b011;
            3: return 3'b010;
            4: return 3'b110;
            5: return 3'b111;
            6: return 3'b101;
            default: return 3'b100;
        endcase
`else
        return 3'(q);
`endif
    endfunction

    function automatic logic [5:0] pk(input logic e, input int p, input logic b, input logic d);
        return {e, seq(p), b, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got en,code,busy,done=%b expected %b", name, got, exp);
        end
    endtask

    typedef struct {
        logic rst, start, stop, step, mode, dir;
        logic en;
        int   pos;
        logic busy, done;
    } vec_t;

    vec_t tbl[25];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [2:0] prev;
        int dcount;

        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 1'b0; dir = 1'b0;
        start2 = 1'b0; stop2 = 1'b0; step2 = 1'b0; mode2 = 1'b0; dir2 = 1'b0;

        //            rst start stop step mode dir | en pos busy done
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

        for (int i = 0; i < 25; i++) begin
            rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop;
            step = tbl[i].step; mode = tbl[i].mode; dir = tbl[i].dir;
            tick();
            chk($sformatf("vec%0d", i), {en, i1, i2, i3, busy, done},
                pk(tbl[i].en, tbl[i].pos, tbl[i].busy, tbl[i].done));
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 1'b0; dir = 1'b0;

        // One-shot up sweep: 32 EN-high cycles, then a single DONE pulse.
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        prev = seq(0);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) tick();
            chk($sformatf("sweep%0d", k), {en, i1, i2, i3, busy, done}, pk(1'b1, k / 4, 1'b1, 1'b0));
`ifdef GRAY_SEQ_EN
            if (k > 0 && (k % 4) == 0) begin
                checks++;
                if ($countones(prev ^ {i1, i2, i3}) != 1) begin
                    errors++;
                    $display("FAIL gray_toggle%0d got %b after %b expected one bit change", k, {i1, i2, i3}, prev);
                end
            end
`endif
            prev = {i1, i2, i3};
        end
        tick();
        chk("sweep_done", {en, i1, i2, i3, busy, done}, pk(1'b0, 0, 1'b0, 1'b1));
        tick();
        chk("sweep_after", {en, i1, i2, i3, busy, done}, pk(1'b0, 0, 1'b0, 1'b0));

        // MODE raised mid-scan: sweep still ends after 8 codes from START.
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) tick();
            chk($sformatf("modechg%0d", k), {en, i1, i2, i3, busy, done}, pk(1'b1, k / 4, 1'b1, 1'b0));
            if (k == 10) mode = 1'b1;
        end
        tick();
        chk("modechg_done", {en, i1, i2, i3, busy, done}, pk(1'b0, 0, 1'b0, 1'b1));

        // Park at position 5, then single step.
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) tick();
        chk("park_scan", {en, i1, i2, i3, busy, done}, pk(1'b1, 5, 1'b1, 1'b0));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("park_stop", {en, i1, i2, i3, busy, done}, pk(1'b0, 5, 1'b0, 1'b0));
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            chk($sformatf("step_hold%0d", k), {en, i1, i2, i3, busy, done}, pk(1'b1, 5, 1'b1, 1'b0));
        end
        tick();
        chk("step_adv", {en, i1, i2, i3, busy, done}, pk(1'b0, 6, 1'b0, 1'b0));

        // Reset at cycle 10 of a one-shot sweep: no DONE afterwards.
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        chk("rstmid_pre", {en, i1, i2, i3, busy, done}, pk(1'b1, 2, 1'b1, 1'b0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid", {en, i1, i2, i3, busy, done}, pk(1'b0, 0, 1'b0, 1'b0));
        dcount = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done || en) dcount++;
        end
        checks++;
        if (dcount != 0) begin
            errors++;
            $display("FAIL rstmid_quiet got %0d active cycles expected 0", dcount);
        end

        // Continuous down scan on dut2 (DWELL_CYCLES=1, START_CODE=2).
        mode2 = 1'b0; dir2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) tick();
            chk($sformatf("down%0d", k), {en2, i1b, i2b, i3b, busy2, done2}, pk(1'b1, 2 - k, 1'b1, 1'b0));
        end
        stop2 = 1'b1;
        tick();
        stop2 = 1'b0;
        chk("down_stop", {en2, i1b, i2b, i3b, busy2, done2}, pk(1'b0, 2 - 39, 1'b0, 1'b0));
        tick();
        chk("down_held", {en2, i1b, i2b, i3b, busy2, done2}, pk(1'b0, 2 - 39, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
